// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   640x480@60Hz VGA raster timing from the 100 MHz system clock.
//   A PIX_DIV divider produces the pixel enable; x/y are the raw raster
//   counters including blanking, so renderers can key on blanking-line
//   coordinates as well as visible ones.
//
// Ports
//   clk         in   system clock (100 MHz)
//   reset       in   asynchronous reset, active-low
//   p_tick      out  pixel enable, high one clk in every PIX_DIV
//   x           out  horizontal counter, 0..H_TOTAL-1
//   y           out  vertical counter, 0..V_TOTAL-1
//   video_on    out  high inside the visible area
//   hsync       out  horizontal sync, active-low, registered
//   vsync       out  vertical sync, active-low, registered
//   frame_tick  out  one-clk pulse on the last pixel of each frame
module vga_sync_gen #(
  parameter int PIX_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(PIX_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]    HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]    HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]    VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] div;
  logic [9:0]    x_next;
  logic [9:0]    y_next;

  always_comb begin
    p_tick = (div == DIV_LAST);
    x_next = x;
    y_next = y;
    if (p_tick) begin
      if (x == H_LAST) begin
        x_next = '0;
        y_next = (y == V_LAST) ? '0 : y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  // Syncs are decoded from the next-counter values so they switch on the
  // same edge as x/y rather than one pixel late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      x     <= '0;
      y     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      div   <= p_tick ? '0 : div + DW'(1);
      x     <= x_next;
      y     <= y_next;
      hsync <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
      vsync <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
    end
  end

  always_comb begin
    video_on   = (x < H_VIS) && (y < V_VIS);
    frame_tick = p_tick && (x == H_LAST) && (y == V_LAST);
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic       p_tick_a, video_on_a, hsync_a, vsync_a, frame_tick_a;
  logic [9:0] x_a, y_a;
  logic       p_tick_b, video_on_b, hsync_b, vsync_b, frame_tick_b;
  logic [9:0] x_b, y_b;

  // Full 640x480 timing: line-level behaviour and mid-frame reset.
  vga_sync_gen dut_a (
    .clk(clk), .reset(reset_a), .p_tick(p_tick_a), .x(x_a), .y(y_a),
    .video_on(video_on_a), .hsync(hsync_a), .vsync(vsync_a),
    .frame_tick(frame_tick_a)
  );

  // Miniature raster (16x12 total, 8x6 visible) so whole frames fit in a
  // short run: frame = 16*12*4 = 768 clks.
  vga_sync_gen #(
    .PIX_DIV(4), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .p_tick(p_tick_b), .x(x_b), .y(y_b),
    .video_on(video_on_b), .hsync(hsync_b), .vsync(vsync_b),
    .frame_tick(frame_tick_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs k clk edges after reset release, from raster geometry.
  // Packing: {7'b0, p_tick, x[9:0], y[9:0], hsync, vsync, video_on, frame_tick}
  function automatic logic [31:0] model(input int k, input int ht, input int hd,
                                        input int hs0, input int hs1, input int vt,
                                        input int vd, input int vs0, input int vs1);
    int p, xx, yy;
    logic pt, hs, vs, vo, ft;
    p  = k / 4;
    xx = p % ht;
    yy = (p / ht) % vt;
    pt = (k % 4) == 3;
    hs = !(xx >= hs0 && xx <= hs1);
    vs = !(yy >= vs0 && yy <= vs1);
    vo = (xx < hd) && (yy < vd);
    ft = pt && (xx == ht - 1) && (yy == vt - 1);
    return {7'b0, pt, 10'(xx), 10'(yy), hs, vs, vo, ft};
  endfunction

  function automatic logic [31:0] model_a(input int k);
    return model(k, 800, 640, 656, 751, 525, 480, 490, 491);
  endfunction

  function automatic logic [31:0] model_b(input int k);
    return model(k, 16, 8, 10, 12, 12, 6, 8, 9);
  endfunction

  function automatic logic [31:0] obs_a();
    return {7'b0, p_tick_a, x_a, y_a, hsync_a, vsync_a, video_on_a, frame_tick_a};
  endfunction

  function automatic logic [31:0] obs_b();
    return {7'b0, p_tick_b, x_b, y_b, hsync_b, vsync_b, video_on_b, frame_tick_b};
  endfunction

  initial begin
    int y0_cnt, hl0_cnt, hl1_cnt;
    int vo_cnt, vl_cnt, y7_cnt, ft_cnt, ft_last;

    reset_a = 1'b0;
    reset_b = 1'b0;
    #22;
    chk("reset_a", obs_a(), model_a(0));
    chk("reset_b", obs_b(), model_b(0));

    // Full-size instance: first three lines, checked every clk.
    @(negedge clk);
    reset_a = 1'b1;
    chk("rel_a", obs_a(), model_a(0));
    y0_cnt = 1; hl0_cnt = 0; hl1_cnt = 0;
    for (int k = 1; k <= 9200; k++) begin
      @(posedge clk); #1;
      chk("raster_a", obs_a(), model_a(k));
      if (y_a == 10'd0) y0_cnt++;
      if (y_a == 10'd0 && !hsync_a) hl0_cnt++;
      if (y_a == 10'd1 && !hsync_a) hl1_cnt++;
      if (k == 3) chk("first_ptick", 32'(p_tick_a), 32'd1);
      if (k == 3200) begin
        chk("line_wrap_x", 32'(x_a), 32'd0);
        chk("line_wrap_y", 32'(y_a), 32'd1);
      end
      if (k == 3199) chk("no_ftick_eol", 32'(frame_tick_a), 32'd0);
    end
    chk("y0_hold_clks", 32'(y0_cnt), 32'd3200);
    chk("hs_low_line0", 32'(hl0_cnt), 32'd384);
    chk("hs_low_line1", 32'(hl1_cnt), 32'd384);

    // Now at x=700, y=2 with hsync low; reset between edges acts at once.
    chk("pre_rst_hs", 32'(hsync_a), 32'd0);
    #3;
    reset_a = 1'b0;
    #1;
    chk("async_rst", obs_a(), model_a(0));
    @(negedge clk);
    reset_a = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("restart_a", obs_a(), model_a(k));
    end

    // Miniature instance: two full frames plus a few clks.
    @(negedge clk);
    reset_b = 1'b1;
    vo_cnt = 1; vl_cnt = 0; y7_cnt = 0; ft_cnt = 0; ft_last = -1;
    for (int k = 1; k <= 2 * 768 + 4; k++) begin
      @(posedge clk); #1;
      chk("raster_b", obs_b(), model_b(k));
      if (k < 768) begin
        if (video_on_b) vo_cnt++;
        if (!vsync_b) vl_cnt++;
        if (y_b == 10'd7 && x_b == 10'd0) y7_cnt++;
      end
      if (x_b == 10'd8 && y_b == 10'd0) chk("vo_8_0", 32'(video_on_b), 32'd0);
      if (x_b == 10'd0 && y_b == 10'd6) chk("vo_0_6", 32'(video_on_b), 32'd0);
      if (frame_tick_b) begin
        chk("ft_at_last", {x_b, y_b}, {10'd15, 10'd11});
        if (ft_last >= 0) chk("ft_period", 32'(k - ft_last), 32'd768);
        ft_last = k;
        ft_cnt++;
      end
      if (k == 768) chk("frame_wrap", {x_b, y_b}, 20'd0);
    end
    chk("vo_clks_frame", 32'(vo_cnt), 32'd192);
    chk("vs_low_clks", 32'(vl_cnt), 32'd128);
    chk("y7_x0_clks", 32'(y7_cnt), 32'd4);
    chk("ft_count", 32'(ft_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
